// File: rtl/imm_gen_pkg.sv
// Shared encodings for the ID-stage immediate generator.
// Holds the immediate-select codes, field widths and the pipe control states.
package imm_gen_pkg;

    localparam int IMM_SEL_W  = 3;
    localparam int INSTR_HI_W = 25;   // instruction[31:7]

    localparam logic [IMM_SEL_W-1:0] IMM_SEL_U  = 3'b000;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_J  = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_S  = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_B  = 3'b011;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_I  = 3'b100;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_SH = 3'b101;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_IU = 3'b110;
    localparam logic [IMM_SEL_W-1:0] IMM_SEL_Z  = 3'b111;

    // Occupancy of the output register / skid buffer pair.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,   // output register invalid
        ST_ONE   = 2'b01,   // output valid, skid empty
        ST_FULL  = 2'b10    // output and skid valid
    } pipe_state_e;

endpackage

// File: rtl/immediate_decode_comb.sv
// Purely combinational immediate extraction from instruction[31:7].
// Field positions are written in terms of the 25-bit slice: instr[k-7] is i[k].
// Optional feature: define ZICSR_IMM_EN to make select 111 return the CSR zimm;
// otherwise 111 yields zero with sel_err set.
module immediate_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_HI_W-1:0] instr,
    input  logic [IMM_SEL_W-1:0]  sel,
    output logic [XLEN-1:0]       imm,
    output logic                  sel_err
);

    // Select and extend the immediate for the requested format.
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        imm     = '0;
        sel_err = 1'b0;
        case (sel)
            // U: i[31:12] << 12
            IMM_SEL_U:  imm = XLEN'($signed({instr[24:5], 12'b0}));
            // J: {i[31], i[19:12], i[20], i[30:21], 0}
            IMM_SEL_J:  imm = XLEN'($signed({instr[24], instr[12:5], instr[13],
                                             instr[23:14], 1'b0}));
            // S: {i[31:25], i[11:7]}
            IMM_SEL_S:  imm = XLEN'($signed({instr[24:18], instr[4:0]}));
            // B: {i[31], i[7], i[30:25], i[11:8], 0}
            IMM_SEL_B:  imm = XLEN'($signed({instr[24], instr[0], instr[23:18],
                                             instr[4:1], 1'b0}));
            // I: i[31:20]
            IMM_SEL_I:  imm = XLEN'($signed(instr[24:13]));
            // Shift amount width follows XLEN: i[24:20] or i[25:20].
            IMM_SEL_SH: begin
                if (XLEN == 32) imm = XLEN'(instr[17:13]);
                else            imm = XLEN'(instr[18:13]);
            end
            // IU: i[31:20] zero-extended
            IMM_SEL_IU: imm = XLEN'(instr[24:13]);
            IMM_SEL_Z: begin
`ifdef ZICSR_IMM_EN
                // CSR zimm lives in the rs1 field i[19:15].
                imm = XLEN'(instr[12:8]);
`else
                sel_err = 1'b1;
`endif
            end
            default: sel_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/immediate_generate_pipe.sv
// Registered, valid/ready immediate generator for the ID stage.
// One output register plus one skid entry: IN_READY is registered and never
// depends combinationally on OUT_READY, yet no entry is lost or duplicated.
// Optional feature: ZICSR_IMM_EN (see immediate_decode_comb) enables the CSR zimm.
module immediate_generate_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [INSTR_HI_W-1:0] IN_INSTR,
    input  logic [IMM_SEL_W-1:0]  IN_IMM_SEL,
    input  logic [TAG_W-1:0]      IN_TAG,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [XLEN-1:0]       OUT_IMM,
    output logic [TAG_W-1:0]      OUT_TAG,
    output logic                  OUT_SEL_ERR
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immediate_generate_pipe: XLEN must be 32 or 64");
    end

    pipe_state_e       state;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_err;
    logic              push;
    logic              pop;
    logic              skid_load;

    immediate_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (IN_INSTR),
        .sel     (IN_IMM_SEL),
        .imm     (dec_imm),
        .sel_err (dec_err)
    );

    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;
    // Only ONE with accept and no pop parks the new entry in the skid.
    assign skid_load = (state == ST_ONE) && push && !pop;

    // Skid payload capture; only written when an entry must be parked.
    always_ff @(posedge CLK) begin
        // NOTE: payload needs no reset; its validity is tracked by state.
        if (skid_load) begin
            skid_imm <= dec_imm;
            skid_tag <= IN_TAG;
            skid_err <= dec_err;
        end
    end

    // Occupancy control and registered output stage.
    always_ff @(posedge CLK) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (RESET || FLUSH) begin
            state       <= ST_EMPTY;
            OUT_VALID   <= 1'b0;
            OUT_IMM     <= '0;
            OUT_TAG     <= '0;
            OUT_SEL_ERR <= 1'b0;
            IN_READY    <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        OUT_VALID   <= 1'b1;
                        OUT_IMM     <= dec_imm;
                        OUT_TAG     <= IN_TAG;
                        OUT_SEL_ERR <= dec_err;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        OUT_IMM     <= dec_imm;
                        OUT_TAG     <= IN_TAG;
                        OUT_SEL_ERR <= dec_err;
                    end else if (push) begin
                        IN_READY    <= 1'b0;
                        state       <= ST_FULL;
                    end else if (pop) begin
                        OUT_VALID   <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        OUT_IMM     <= skid_imm;
                        OUT_TAG     <= skid_tag;
                        OUT_SEL_ERR <= skid_err;
                        IN_READY    <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    OUT_VALID   <= 1'b0;
                    IN_READY    <= 1'b1;
                end
            endcase
        end
    end

endmodule
